// File: rtl/mandelbrot_iter_pipe_if.sv
// Point-in / result-out handshake bundle for the Mandelbrot iteration ring.
`timescale 1ns/1ps
interface mandelbrot_iter_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 8,
    parameter int TAG_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_cx;
    logic signed [WIDTH-1:0] in_cy;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [ITER_W-1:0]       out_iter;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_escaped;

    modport master (
        output in_valid, in_cx, in_cy, in_tag, out_ready,
        input  in_ready, out_valid, out_iter, out_tag, out_escaped
    );

    modport slave (
        input  in_valid, in_cx, in_cy, in_tag, out_ready,
        output in_ready, out_valid, out_iter, out_tag, out_escaped
    );
endinterface

// File: rtl/mandelbrot_iter_pipe.sv
// Three-stage recirculating z = z^2 + c ring; retires each tagged point with its
// escape iteration count through a single output register.
`timescale 1ns/1ps
module mandelbrot_iter_pipe #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 28,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int TAG_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mandelbrot_iter_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam logic [PW:0] ESC_LIM = (PW+1)'(4) << FRAC;

    logic                    s0_valid_q, s0_valid_d;
    logic [TAG_W-1:0]        s0_tag_q, s0_tag_d;
    logic signed [WIDTH-1:0] s0_cx_q, s0_cx_d, s0_cy_q, s0_cy_d;
    logic signed [WIDTH-1:0] s0_zx_q, s0_zx_d, s0_zy_q, s0_zy_d;
    logic [ITER_W-1:0]       s0_iter_q, s0_iter_d;

    logic                    s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;
    logic signed [WIDTH-1:0] s1_cx_q, s1_cx_d, s1_cy_q, s1_cy_d;
    logic [ITER_W-1:0]       s1_iter_q, s1_iter_d;
    logic signed [PW-1:0]    s1_xx_q, s1_xx_d, s1_yy_q, s1_yy_d, s1_xy_q, s1_xy_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;
    logic signed [WIDTH-1:0] s2_cx_q, s2_cx_d, s2_cy_q, s2_cy_d;
    logic signed [WIDTH-1:0] s2_zx_q, s2_zx_d, s2_zy_q, s2_zy_d;
    logic [ITER_W-1:0]       s2_iter_q, s2_iter_d;
    logic                    s2_esc_q, s2_esc_d;

    logic                    out_valid_q, out_valid_d;
    logic [ITER_W-1:0]       out_iter_q, out_iter_d;
    logic [TAG_W-1:0]        out_tag_q, out_tag_d;
    logic                    out_esc_q, out_esc_d;

    logic                    retire, recirc, stall, in_ready, accept;
    logic signed [PW-1:0]    zx_ext, zy_ext;
    logic [PW:0]             mag_sum;
    logic signed [PW:0]      diff, xy2;

    always_comb begin
        s0_valid_d = s0_valid_q;  s0_tag_d = s0_tag_q;  s0_cx_d = s0_cx_q;  s0_cy_d = s0_cy_q;
        s0_zx_d    = s0_zx_q;     s0_zy_d  = s0_zy_q;   s0_iter_d = s0_iter_q;
        s1_valid_d = s1_valid_q;  s1_tag_d = s1_tag_q;  s1_cx_d = s1_cx_q;  s1_cy_d = s1_cy_q;
        s1_iter_d  = s1_iter_q;   s1_xx_d  = s1_xx_q;   s1_yy_d = s1_yy_q;  s1_xy_d = s1_xy_q;
        s2_valid_d = s2_valid_q;  s2_tag_d = s2_tag_q;  s2_cx_d = s2_cx_q;  s2_cy_d = s2_cy_q;
        s2_zx_d    = s2_zx_q;     s2_zy_d  = s2_zy_q;   s2_iter_d = s2_iter_q;
        s2_esc_d   = s2_esc_q;
        out_valid_d = out_valid_q;
        out_iter_d  = out_iter_q;
        out_tag_d   = out_tag_q;
        out_esc_d   = out_esc_q;

        zx_ext = PW'(s0_zx_q);
        zy_ext = PW'(s0_zy_q);
        // Squares are non-negative, so an unsigned sum one bit wider never wraps.
        mag_sum = {1'b0, s1_xx_q} + {1'b0, s1_yy_q};
        diff    = $signed({s1_xx_q[PW-1], s1_xx_q}) - $signed({s1_yy_q[PW-1], s1_yy_q});
        xy2     = {s1_xy_q, 1'b0};

        retire   = s2_valid_q && (s2_esc_q || (s2_iter_q == ITER_W'(MAX_ITER)));
        recirc   = s2_valid_q && !retire;
        stall    = retire && out_valid_q && !bus.out_ready;
        in_ready = !stall && !recirc;
        accept   = bus.in_valid && in_ready;

        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s2_tag_d   = s1_tag_q;
            s2_cx_d    = s1_cx_q;
            s2_cy_d    = s1_cy_q;
            s2_iter_d  = s1_iter_q;
            s2_zx_d    = WIDTH'(diff >>> FRAC) + s1_cx_q;
            s2_zy_d    = WIDTH'(xy2 >>> FRAC) + s1_cy_q;
            s2_esc_d   = (mag_sum >> FRAC) > ESC_LIM;

            s1_valid_d = s0_valid_q;
            s1_tag_d   = s0_tag_q;
            s1_cx_d    = s0_cx_q;
            s1_cy_d    = s0_cy_q;
            s1_iter_d  = s0_iter_q;
            s1_xx_d    = zx_ext * zx_ext;
            s1_yy_d    = zy_ext * zy_ext;
            s1_xy_d    = zx_ext * zy_ext;

            // A point still iterating owns the S0 slot over any new input.
            if (recirc) begin
                s0_valid_d = 1'b1;
                s0_tag_d   = s2_tag_q;
                s0_cx_d    = s2_cx_q;
                s0_cy_d    = s2_cy_q;
                s0_zx_d    = s2_zx_q;
                s0_zy_d    = s2_zy_q;
                s0_iter_d  = s2_iter_q + ITER_W'(1);
            end else if (accept) begin
                s0_valid_d = 1'b1;
                s0_tag_d   = bus.in_tag;
                s0_cx_d    = bus.in_cx;
                s0_cy_d    = bus.in_cy;
                s0_zx_d    = '0;
                s0_zy_d    = '0;
                s0_iter_d  = '0;
            end else begin
                s0_valid_d = 1'b0;
            end
        end

        if (retire && !stall) begin
            out_valid_d = 1'b1;
            out_iter_d  = s2_iter_q;
            out_tag_d   = s2_tag_q;
            out_esc_d   = s2_esc_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;  s0_tag_q <= '0;  s0_cx_q <= '0;  s0_cy_q <= '0;
            s0_zx_q    <= '0;    s0_zy_q  <= '0;  s0_iter_q <= '0;
            s1_valid_q <= 1'b0;  s1_tag_q <= '0;  s1_cx_q <= '0;  s1_cy_q <= '0;
            s1_iter_q  <= '0;    s1_xx_q  <= '0;  s1_yy_q <= '0;  s1_xy_q <= '0;
            s2_valid_q <= 1'b0;  s2_tag_q <= '0;  s2_cx_q <= '0;  s2_cy_q <= '0;
            s2_zx_q    <= '0;    s2_zy_q  <= '0;  s2_iter_q <= '0;
            s2_esc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_iter_q  <= '0;
            out_tag_q   <= '0;
            out_esc_q   <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;  s0_tag_q <= s0_tag_d;  s0_cx_q <= s0_cx_d;  s0_cy_q <= s0_cy_d;
            s0_zx_q    <= s0_zx_d;     s0_zy_q  <= s0_zy_d;   s0_iter_q <= s0_iter_d;
            s1_valid_q <= s1_valid_d;  s1_tag_q <= s1_tag_d;  s1_cx_q <= s1_cx_d;  s1_cy_q <= s1_cy_d;
            s1_iter_q  <= s1_iter_d;   s1_xx_q  <= s1_xx_d;   s1_yy_q <= s1_yy_d;  s1_xy_q <= s1_xy_d;
            s2_valid_q <= s2_valid_d;  s2_tag_q <= s2_tag_d;  s2_cx_q <= s2_cx_d;  s2_cy_q <= s2_cy_d;
            s2_zx_q    <= s2_zx_d;     s2_zy_q  <= s2_zy_d;   s2_iter_q <= s2_iter_d;
            s2_esc_q   <= s2_esc_d;
            out_valid_q <= out_valid_d;
            out_iter_q  <= out_iter_d;
            out_tag_q   <= out_tag_d;
            out_esc_q   <= out_esc_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_iter    = out_iter_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_escaped = out_esc_q;
endmodule

// File: tb/tb_mandelbrot_iter_pipe.sv
// Scoreboard bench for mandelbrot_iter_pipe with a 128-bit reference iteration model.
`timescale 1ns/1ps
module tb_mandelbrot_iter_pipe;
    localparam int W      = 32;
    localparam int FRAC   = 28;
    localparam int IW     = 8;
    localparam int MAX_IT = 15;
    localparam int TW     = 16;
    localparam logic signed [W-1:0] ONE = 32'sh1000_0000;

    typedef struct {
        logic [TW-1:0] tag;
        logic [IW-1:0] iter;
        logic          esc;
        int            acc;
        int            lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   first_cyc;
    bit   held;
    exp_t sb[$];
    logic [TW-1:0] cons_tag[$];
    int   cons_cyc[$];

    mandelbrot_iter_pipe_if #(.WIDTH(W), .ITER_W(IW), .TAG_W(TW)) bus ();

    mandelbrot_iter_pipe #(
        .WIDTH(W), .FRAC(FRAC), .ITER_W(IW), .MAX_ITER(MAX_IT), .TAG_W(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void ref_model(input logic signed [W-1:0] cx, input logic signed [W-1:0] cy,
                                      output logic [IW-1:0] it, output logic esc);
        logic signed [127:0] zx, zy, xx, yy, xy, mag, nzx, nzy, lim;
        zx  = 0;
        zy  = 0;
        esc = 1'b0;
        it  = '0;
        lim = 128'sd4 <<< FRAC;
        for (int i = 0; i <= MAX_IT; i++) begin
            xx  = zx * zx;
            yy  = zy * zy;
            xy  = zx * zy;
            mag = (xx + yy) >>> FRAC;
            it  = IW'(i);
            if (mag > lim) begin
                esc = 1'b1;
                return;
            end
            if (i == MAX_IT) return;
            nzx = ((xx - yy) >>> FRAC) + 128'(cx);
            nzy = ((xy <<< 1) >>> FRAC) + 128'(cy);
            zx  = 128'($signed(nzx[W-1:0]));
            zy  = 128'($signed(nzy[W-1:0]));
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [TW-1:0] tag, input logic signed [W-1:0] cx,
                        input logic signed [W-1:0] cy, input bit with_lat);
        exp_t e;
        logic [IW-1:0] it;
        logic es;
        int n;
        ref_model(cx, cy, it, es);
        bus.in_valid = 1'b1;
        bus.in_tag   = tag;
        bus.in_cx    = cx;
        bus.in_cy    = cy;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check_val("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.tag  = tag;
        e.iter = it;
        e.esc  = es;
        e.acc  = cyc;
        e.lat  = with_lat ? 3 * (int'(it) + 1) : -1;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("out_valid_seen", 64'(bus.out_valid), 64'd1);
    endtask

    always @(negedge clk) begin
        int idx;
        if (!rst_n) begin
            held = 1'b0;
        end else if (bus.out_valid) begin
            if (!held) begin
                first_cyc = cyc;
                held = 1'b1;
            end
            if (bus.out_ready) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].tag == bus.out_tag) idx = i;
                check_val("tag_known", 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    check_val("iter", 64'(bus.out_iter), 64'(sb[idx].iter));
                    check_val("escaped", 64'(bus.out_escaped), 64'(sb[idx].esc));
                    if (sb[idx].lat >= 0)
                        check_val("latency", 64'(first_cyc - sb[idx].acc), 64'(sb[idx].lat));
                    sb.delete(idx);
                end
                cons_tag.push_back(bus.out_tag);
                cons_cyc.push_back(cyc);
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic signed [W-1:0] rcx, rcy;
        n_chk = 0;
        n_pass = 0;
        held = 1'b0;
        first_cyc = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_tag    = '0;
        bus.in_cx     = '0;
        bus.in_cy     = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_out_iter", 64'(bus.out_iter), 64'd0);
        check_val("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check_val("rst_out_escaped", 64'(bus.out_escaped), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single points with exact latency.
        send(16'h0011, 0, 0, 1'b1);        drain();
        send(16'h0022, 2 * ONE, 0, 1'b1);  drain();
        send(16'h0033, 3 * ONE, 0, 1'b1);  drain();
        send(16'h0044, -2 * ONE, 0, 1'b1); drain();

        // Long point then short point: short one overtakes.
        cons_tag.delete();
        send(16'h000A, 0, 0, 1'b1);
        send(16'h000B, 3 * ONE, 0, 1'b1);
        @(negedge clk);
        check_val("ready_recirc_slot", 64'(bus.in_ready), 64'd0);
        drain();
        check_val("ooo_count", 64'(cons_tag.size()), 64'd2);
        if (cons_tag.size() == 2) begin
            check_val("ooo_first", 64'(cons_tag[0]), 64'h000B);
            check_val("ooo_second", 64'(cons_tag[1]), 64'h000A);
        end

        // Random c in [-2,1) x [-1.5,1.5), issued as fast as the ring allows.
        for (int i = 0; i < 10; i++) begin
            rcx = W'($signed($urandom_range(0, 32'h3000_0000)) - 32'sh2000_0000);
            rcy = W'($signed($urandom_range(0, 32'h3000_0000)) - 32'sh1800_0000);
            send(16'h0080 + TW'(i), rcx, rcy, 1'b0);
        end
        drain();

        // Backpressure: first result held, ring stalls, then three back-to-back.
        cons_tag.delete();
        cons_cyc.delete();
        bus.out_ready = 1'b0;
        send(16'h0061, 3 * ONE, 0, 1'b1);
        send(16'h0062, 3 * ONE, 0, 1'b0);
        send(16'h0063, 3 * ONE, 0, 1'b0);
        wait_out_valid();
        repeat (10) @(negedge clk);
        check_val("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("stall_out_tag", 64'(bus.out_tag), 64'h0061);
        check_val("stall_out_iter", 64'(bus.out_iter), 64'd1);
        check_val("stall_out_escaped", 64'(bus.out_escaped), 64'd1);
        check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();
        check_val("stall_count", 64'(cons_tag.size()), 64'd3);
        if (cons_tag.size() == 3) begin
            check_val("stall_order0", 64'(cons_tag[0]), 64'h0061);
            check_val("stall_order1", 64'(cons_tag[1]), 64'h0062);
            check_val("stall_order2", 64'(cons_tag[2]), 64'h0063);
            check_val("b2b_gap1", 64'(cons_cyc[1] - cons_cyc[0]), 64'd1);
            check_val("b2b_gap2", 64'(cons_cyc[2] - cons_cyc[1]), 64'd1);
        end

        // Reset with ring full and a result held: everything discarded.
        bus.out_ready = 1'b0;
        send(16'h0071, 3 * ONE, 0, 1'b0);
        send(16'h0072, 3 * ONE, 0, 1'b0);
        send(16'h0073, 3 * ONE, 0, 1'b0);
        wait_out_valid();
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_out_iter", 64'(bus.out_iter), 64'd0);
        check_val("mid_rst_out_tag", 64'(bus.out_tag), 64'd0);
        check_val("mid_rst_out_escaped", 64'(bus.out_escaped), 64'd0);
        check_val("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        cons_tag.delete();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0077, 3 * ONE, 0, 1'b1);
        drain();
        repeat (20) @(negedge clk);
        check_val("post_rst_count", 64'(cons_tag.size()), 64'd1);
        if (cons_tag.size() >= 1)
            check_val("post_rst_tag", 64'(cons_tag[0]), 64'h0077);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mandelbrot_iter_pipe.md
# mandelbrot_iter_pipe

Parametrised fixed-point Mandelbrot iteration engine. It is the next generation of the compute_0/compute_1 squaring and combining stages, closed into a recirculating three-stage ring that iterates z = z² + c per point. The block accepts tagged points c = (cx, cy) over a valid/ready handshake and keeps up to three points in flight. It retires each point with its escape iteration count, possibly out of order, and sits between the pixel-coordinate generator and the colour mapper.

## Interface
- WIDTH, 32, total bits of signed fixed-point cx, cy, zx, zy; must be ≥ 8
- FRAC, 28, fractional bits; WIDTH-FRAC ≥ 4
- ITER_W, 8, width of iteration count
- MAX_ITER, 255, iteration cap; 1 ≤ MAX_ITER ≤ 2^ITER_W-1
- TAG_W, 16, opaque point identifier width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input point offered
- in_ready  out  1  block accepts point this cycle; combinational
- in_cx, in_cy  in  WIDTH  signed Q(WIDTH-FRAC).FRAC c
- in_tag  in  TAG_W  point identifier
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_iter  out  ITER_W  escape iteration count
- out_tag  out  TAG_W  tag of retired point
- out_escaped  out  1  1 = |z|²>4 reached; 0 = hit MAX_ITER

## Operation
- Ring registers:
  - S0 holds valid, tag, cx, cy, zx, zy, iter.
  - S1 holds valid, tag, cx, cy, iter, full 2·WIDTH signed products xx = zx·zx, yy = zy·zy, xy = zx·zy.
  - S2 holds valid, tag, cx, cy, iter, new zx, new zy, esc.
- S1→S2 arithmetic:
  - mag = (xx+yy)>>>FRAC, computed unsigned in 2·WIDTH+1 bits with no wrap.
  - esc = mag > (4<<FRAC), strictly greater than.
  - new zx = ((xx−yy)>>>FRAC) + cx, truncated to WIDTH (two's-complement wrap).
  - new zy = ((xy<<<1)>>>FRAC) + cy, truncated to WIDTH.
  - Shifts are arithmetic; low bits are truncated toward −∞, with no rounding.
- Retire condition at S2: s2_valid && (esc || iter == MAX_ITER).
  - On retire, load the output register: out_iter = iter, out_escaped = esc.
  - esc takes precedence when both esc and iter == MAX_ITER hold.
- Otherwise, when s2_valid, recirculate S2→S0 with iter+1 and the new z.
- New point load into S0: zx = zy = 0, iter = 0.
- S0 input priority: recirculation beats a new input.
- stall = s2_valid && retire && out_valid && !out_ready. While stall is high, S0, S1 and S2 all hold.
- in_ready = !stall && !(s2_valid && !retire).
- Output register:
  - Loaded when retiring and (!out_valid || out_ready).
  - Cleared when out_valid && out_ready with no simultaneous load.
  - Simultaneous consume and load gives back-to-back results with no bubble.
- Results may leave out of order; out_tag identifies the point. No reordering is done.

## Timing
- Reset (async assert, sync-to-clk deassert externally):
  - All stage valids = 0.
  - out_valid, out_iter, out_tag, out_escaped = 0.
  - in_ready = 1.
- Reset mid-operation discards all in-flight points and the held result; nothing is emitted for them.
- One pass takes 3 cycles. A point accepted at edge E with result count k, unstalled, gives out_valid high after edge E+3(k+1).
- The empty ring accepts 3 consecutive points. A 4th is refused while a non-retiring point sits in S2.
- Occupancy is at most 3 in the ring plus 1 in the output register.
- Output holds stable while out_valid && !out_ready.

## Test plan
- c=(0,0), MAX_ITER=15, tag 0x11 -> out_iter=15, out_escaped=0, out_valid rises 48 cycles after accept.
- c=(2.0,0) -> out_iter=2, out_escaped=1, after 9 cycles. At |z|²=4 there is no escape; at 36 it escapes.
- c=(3.0,0) -> iter=1, escaped=1, 6 cycles. c=(−2.0,0), MAX_ITER=15 -> iter=15, escaped=0 (fixed point z=2).
- Tag A c=0 then tag B c=(3,0) on the next cycle -> B retires first, then A; in_ready=0 during A's recirculation slot.
- out_ready=0 with 3 short-escape points in flight -> first result held stable, ring stalls, in_ready=0. Release out_ready -> all 3 delivered on consecutive cycles, no loss or duplication.
- Assert rst_n=0 with 3 points in flight and out_valid=1 -> all outputs 0 immediately, in_ready=1. After release, a fresh c=(3,0) returns iter=1 with no stale results.
